// File: rtl/enigma_pkg.sv
// enigma_pkg: shared letter/one-hot types, alphabet size and rotor notch positions
package enigma_pkg;
  localparam int LETTERS = 26;
  typedef logic [4:0] letter_t;
  typedef logic [LETTERS-1:0] onehot_t;
  localparam letter_t NOTCH_I   = 5'd16;
  localparam letter_t NOTCH_II  = 5'd4;
  localparam letter_t NOTCH_III = 5'd21;
  localparam letter_t NOTCH_IV  = 5'd9;
  localparam letter_t NOTCH_V   = 5'd25;
  function automatic logic is_onehot(input onehot_t v);
    return (v != '0) && ((v & (v - 26'd1)) == '0);
  endfunction
endpackage

// File: rtl/rotor_position_if.sv
// rotor_position_if: control, letter and wiring-filter signals of one rotor stage
interface rotor_position_if;
  import enigma_pkg::*;
  logic LOAD, STEP, AT_NOTCH, IN_VALID, OUT_VALID, ERR;
  letter_t POS_IN, RING_IN, POS;
  onehot_t FWD_IN, INV_IN, FWD_TO_WIRE, INV_TO_WIRE, FWD_FROM_WIRE, INV_FROM_WIRE, FWD_OUT, INV_OUT;
  modport slave (
    input LOAD, POS_IN, RING_IN, STEP, IN_VALID, FWD_IN, INV_IN, FWD_FROM_WIRE, INV_FROM_WIRE,
    output POS, AT_NOTCH, FWD_TO_WIRE, INV_TO_WIRE, FWD_OUT, INV_OUT, OUT_VALID, ERR
  );
  modport master (
    output LOAD, POS_IN, RING_IN, STEP, IN_VALID, FWD_IN, INV_IN, FWD_FROM_WIRE, INV_FROM_WIRE,
    input POS, AT_NOTCH, FWD_TO_WIRE, INV_TO_WIRE, FWD_OUT, INV_OUT, OUT_VALID, ERR
  );
endinterface

// File: rtl/onehot_rotate.sv
// onehot_rotate: 26-bit ring rotate; dir=0 moves bit i to i+amt, dir=1 moves bit i+amt to i
module onehot_rotate
  import enigma_pkg::*;
(
  input  onehot_t d,
  input  letter_t amt,
  input  logic    dir,
  output onehot_t q
);
  logic [2*LETTERS-1:0] dd;
  always_comb begin
    dd = {d, d};
    q = dir ? onehot_t'(dd >> amt) : onehot_t'((dd << amt) >> LETTERS);
  end
endmodule

// File: rtl/rotor_position.sv
// rotor_position: rotor position/ring registers and contact-frame offset around a wiring filter
// Define ROTOR_ONEHOT_CHECK_EN to add the sticky one-hot violation flag on ERR.
module rotor_position
  import enigma_pkg::*;
#(
  parameter letter_t NOTCH = NOTCH_II
) (
  input logic CLK,
  input logic RESET_N,
  rotor_position_if.slave bus
);
  letter_t pos_q, pos_d, ring_q, ring_d, off;
  onehot_t fwd_out_q, fwd_out_d, inv_out_q, inv_out_d, fwd_exit, inv_exit;
  logic out_valid_q, out_valid_d;
  logic [5:0] diff;
  // offset stays in 6 bits so a negative POS-RING wraps mod 26, not mod 32
  always_comb begin
    diff = {1'b0, pos_q} + 6'd26 - {1'b0, ring_q};
    off = (diff >= 6'd26) ? 5'(diff - 6'd26) : diff[4:0];
    pos_d = (bus.LOAD && bus.POS_IN < 5'd26) ? bus.POS_IN :
            bus.LOAD ? pos_q :
            bus.STEP ? ((pos_q == 5'd25) ? 5'd0 : pos_q + 5'd1) : pos_q;
    ring_d = (bus.LOAD && bus.RING_IN < 5'd26) ? bus.RING_IN : ring_q;
    out_valid_d = bus.IN_VALID;
    fwd_out_d = bus.IN_VALID ? fwd_exit : fwd_out_q;
    inv_out_d = bus.IN_VALID ? inv_exit : inv_out_q;
  end
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      pos_q <= '0;
      ring_q <= '0;
      fwd_out_q <= '0;
      inv_out_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      pos_q <= pos_d;
      ring_q <= ring_d;
      fwd_out_q <= fwd_out_d;
      inv_out_q <= inv_out_d;
      out_valid_q <= out_valid_d;
    end
  end
  onehot_rotate u_ent_fwd (.d(bus.FWD_IN), .amt(off), .dir(1'b0), .q(bus.FWD_TO_WIRE));
  onehot_rotate u_ent_inv (.d(bus.INV_IN), .amt(off), .dir(1'b0), .q(bus.INV_TO_WIRE));
  onehot_rotate u_ext_fwd (.d(bus.FWD_FROM_WIRE), .amt(off), .dir(1'b1), .q(fwd_exit));
  onehot_rotate u_ext_inv (.d(bus.INV_FROM_WIRE), .amt(off), .dir(1'b1), .q(inv_exit));
  assign bus.POS = pos_q;
  assign bus.AT_NOTCH = (pos_q == NOTCH);
  assign bus.FWD_OUT = fwd_out_q;
  assign bus.INV_OUT = inv_out_q;
  assign bus.OUT_VALID = out_valid_q;
`ifdef ROTOR_ONEHOT_CHECK_EN
  logic err_q, err_d;
  always_comb err_d = err_q | (bus.IN_VALID & ~(is_onehot(bus.FWD_IN) & is_onehot(bus.INV_IN)));
  always_ff @(posedge CLK) begin
    if (!RESET_N) err_q <= 1'b0;
    else err_q <= err_d;
  end
  assign bus.ERR = err_q;
`else
  assign bus.ERR = 1'b0;
`endif
endmodule

// File: tb/tb_rotor_position.sv
// tb_rotor_position: directed self-checking bench for rotor_position
module tb_rotor_position;
  import enigma_pkg::*;
  logic clk, rst_n, loop;
  onehot_t fwd_fw, inv_fw;
  int checks, errors;
  rotor_position_if bus();
  rotor_position dut (.CLK(clk), .RESET_N(rst_n), .bus(bus.slave));
  assign bus.FWD_FROM_WIRE = loop ? bus.FWD_TO_WIRE : fwd_fw;
  assign bus.INV_FROM_WIRE = loop ? bus.INV_TO_WIRE : inv_fw;
  always #5 clk = ~clk;
`ifdef ROTOR_ONEHOT_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input letter_t p, input letter_t r);
    bus.LOAD = 1; bus.POS_IN = p; bus.RING_IN = r;
    cyc();
    bus.LOAD = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    bus.IN_VALID = 1; bus.FWD_IN = 26'd1; bus.INV_IN = 26'd1;
    cyc(); cyc();
    bus.IN_VALID = 0;
    checks++; if (bus.POS !== 5'd0) begin errors++; $display("FAIL reset_pos got=%0d exp=0", bus.POS); end
    checks++; if (bus.OUT_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.OUT_VALID); end
    checks++; if (bus.FWD_OUT !== 26'd0) begin errors++; $display("FAIL reset_fwd_out got=%h exp=0", bus.FWD_OUT); end
    checks++; if (bus.ERR !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", bus.ERR); end
    rst_n = 1;
    cyc();
  endtask

  task automatic test_forward();
    load(5'd1, 5'd0);
    checks++; if (bus.POS !== 5'd1) begin errors++; $display("FAIL fwd_load_pos got=%0d exp=1", bus.POS); end
    bus.FWD_IN = 26'd1; bus.INV_IN = 26'd1 << 3; bus.IN_VALID = 1;
    #1;
    checks++; if (bus.FWD_TO_WIRE !== 26'd2) begin errors++; $display("FAIL fwd_to_wire got=%h exp=%h", bus.FWD_TO_WIRE, 26'd2); end
    checks++; if (bus.INV_TO_WIRE !== 26'd1 << 4) begin errors++; $display("FAIL inv_to_wire_off1 got=%h exp=%h", bus.INV_TO_WIRE, 26'd1 << 4); end
    checks++; if (bus.OUT_VALID !== 1'b0) begin errors++; $display("FAIL fwd_valid_early got=%b exp=0", bus.OUT_VALID); end
    cyc();
    bus.IN_VALID = 0;
    checks++; if (bus.OUT_VALID !== 1'b1) begin errors++; $display("FAIL fwd_valid got=%b exp=1", bus.OUT_VALID); end
    checks++; if (bus.FWD_OUT !== 26'd1) begin errors++; $display("FAIL fwd_out_loop got=%h exp=%h", bus.FWD_OUT, 26'd1); end
    checks++; if (bus.INV_OUT !== 26'd1 << 3) begin errors++; $display("FAIL inv_out_loop got=%h exp=%h", bus.INV_OUT, 26'd1 << 3); end
    bus.FWD_IN = 26'd1 << 9;
    cyc();
    checks++; if (bus.OUT_VALID !== 1'b0) begin errors++; $display("FAIL valid_drop got=%b exp=0", bus.OUT_VALID); end
    checks++; if (bus.FWD_OUT !== 26'd1) begin errors++; $display("FAIL fwd_out_hold got=%h exp=%h", bus.FWD_OUT, 26'd1); end
  endtask

  task automatic test_exit();
    loop = 0; fwd_fw = 26'd1 << 5; inv_fw = 26'd1;
    bus.IN_VALID = 1;
    cyc();
    bus.IN_VALID = 0;
    checks++; if (bus.FWD_OUT !== 26'd1 << 4) begin errors++; $display("FAIL exit_fwd got=%h exp=%h", bus.FWD_OUT, 26'd1 << 4); end
    checks++; if (bus.INV_OUT !== 26'd1 << 25) begin errors++; $display("FAIL exit_inv_wrap got=%h exp=%h", bus.INV_OUT, 26'd1 << 25); end
    loop = 1;
  endtask

  task automatic test_ring();
    load(5'd0, 5'd1);
    bus.INV_IN = 26'd1; bus.FWD_IN = 26'd1;
    #1;
    checks++; if (bus.INV_TO_WIRE !== 26'd1 << 25) begin errors++; $display("FAIL ring_inv_to_wire got=%h exp=%h", bus.INV_TO_WIRE, 26'd1 << 25); end
    checks++; if (bus.FWD_TO_WIRE !== 26'd1 << 25) begin errors++; $display("FAIL ring_fwd_to_wire got=%h exp=%h", bus.FWD_TO_WIRE, 26'd1 << 25); end
    load(5'd3, 5'd20);
    bus.FWD_IN = 26'd1 << 20;
    #1;
    checks++; if (bus.FWD_TO_WIRE !== 26'd1 << 3) begin errors++; $display("FAIL ring_mod26 got=%h exp=%h", bus.FWD_TO_WIRE, 26'd1 << 3); end
  endtask

  task automatic test_step();
    load(5'd24, 5'd0);
    bus.STEP = 1;
    cyc();
    checks++; if (bus.POS !== 5'd25) begin errors++; $display("FAIL step_to_25 got=%0d exp=25", bus.POS); end
    cyc();
    bus.STEP = 0;
    checks++; if (bus.POS !== 5'd0) begin errors++; $display("FAIL step_wrap got=%0d exp=0", bus.POS); end
    load(5'd3, 5'd0);
    checks++; if (bus.AT_NOTCH !== 1'b0) begin errors++; $display("FAIL notch_off got=%b exp=0", bus.AT_NOTCH); end
    bus.STEP = 1;
    cyc();
    bus.STEP = 0;
    checks++; if (bus.POS !== 5'd4) begin errors++; $display("FAIL step_to_notch got=%0d exp=4", bus.POS); end
    checks++; if (bus.AT_NOTCH !== 1'b1) begin errors++; $display("FAIL notch_on got=%b exp=1", bus.AT_NOTCH); end
    load(5'd30, 5'd27);
    checks++; if (bus.POS !== 5'd4) begin errors++; $display("FAIL load_bad_pos got=%0d exp=4", bus.POS); end
    bus.FWD_IN = 26'd1;
    #1;
    checks++; if (bus.FWD_TO_WIRE !== 26'd1 << 4) begin errors++; $display("FAIL load_bad_ring got=%h exp=%h", bus.FWD_TO_WIRE, 26'd1 << 4); end
  endtask

  task automatic test_load_step();
    bus.STEP = 1;
    load(5'd7, 5'd0);
    checks++; if (bus.POS !== 5'd7) begin errors++; $display("FAIL load_beats_step got=%0d exp=7", bus.POS); end
    load(5'd31, 5'd0);
    bus.STEP = 0;
    checks++; if (bus.POS !== 5'd7) begin errors++; $display("FAIL bad_load_drops_step got=%0d exp=7", bus.POS); end
  endtask

  task automatic test_step_valid();
    load(5'd1, 5'd0);
    loop = 0; fwd_fw = 26'd2;
    bus.STEP = 1; bus.IN_VALID = 1; bus.FWD_IN = 26'd1;
    #1;
    checks++; if (bus.FWD_TO_WIRE !== 26'd2) begin errors++; $display("FAIL sv_to_wire got=%h exp=%h", bus.FWD_TO_WIRE, 26'd2); end
    cyc();
    bus.STEP = 0; bus.IN_VALID = 0;
    #1;
    checks++; if (bus.POS !== 5'd2) begin errors++; $display("FAIL sv_pos got=%0d exp=2", bus.POS); end
    checks++; if (bus.FWD_OUT !== 26'd1) begin errors++; $display("FAIL sv_pre_step_off got=%h exp=%h", bus.FWD_OUT, 26'd1); end
    checks++; if (bus.FWD_TO_WIRE !== 26'd4) begin errors++; $display("FAIL sv_post_step_off got=%h exp=%h", bus.FWD_TO_WIRE, 26'd4); end
    loop = 1;
  endtask

  task automatic test_onehot();
    bus.FWD_IN = 26'h3; bus.INV_IN = 26'd1; bus.IN_VALID = 0;
    cyc();
    checks++; if (bus.ERR !== 1'b0) begin errors++; $display("FAIL err_needs_valid got=%b exp=0", bus.ERR); end
    bus.IN_VALID = 1;
    cyc();
    bus.IN_VALID = 0; bus.FWD_IN = 26'd1;
    checks++; if (bus.ERR !== EXP_ERR) begin errors++; $display("FAIL err_set got=%b exp=%b", bus.ERR, EXP_ERR); end
    bus.IN_VALID = 1;
    cyc(); cyc();
    bus.IN_VALID = 0;
    checks++; if (bus.ERR !== EXP_ERR) begin errors++; $display("FAIL err_sticky got=%b exp=%b", bus.ERR, EXP_ERR); end
  endtask

  task automatic test_reset_mid();
    load(5'd9, 5'd2);
    bus.IN_VALID = 1; bus.FWD_IN = 26'd1; bus.STEP = 1; rst_n = 0;
    cyc();
    bus.IN_VALID = 0; bus.STEP = 0; rst_n = 1;
    checks++; if (bus.POS !== 5'd0) begin errors++; $display("FAIL mid_reset_pos got=%0d exp=0", bus.POS); end
    checks++; if (bus.OUT_VALID !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got=%b exp=0", bus.OUT_VALID); end
    checks++; if (bus.FWD_OUT !== 26'd0) begin errors++; $display("FAIL mid_reset_fwd got=%h exp=0", bus.FWD_OUT); end
    checks++; if (bus.ERR !== 1'b0) begin errors++; $display("FAIL mid_reset_err got=%b exp=0", bus.ERR); end
    bus.FWD_IN = 26'd1;
    #1;
    checks++; if (bus.FWD_TO_WIRE !== 26'd1) begin errors++; $display("FAIL mid_reset_ring got=%h exp=%h", bus.FWD_TO_WIRE, 26'd1); end
  endtask

  initial begin
    clk = 0; rst_n = 0; loop = 1; fwd_fw = '0; inv_fw = '0;
    checks = 0; errors = 0;
    bus.LOAD = 0; bus.STEP = 0; bus.POS_IN = '0; bus.RING_IN = '0;
    bus.IN_VALID = 0; bus.FWD_IN = '0; bus.INV_IN = '0;
    test_reset();
    test_forward();
    test_exit();
    test_ring();
    test_step();
    test_load_step();
    test_step_valid();
    test_onehot();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rotor_position.md
# rotor_position

Per-rotor position and offset stage wrapped around a fixed rotor wiring filter. It holds the rotor's current position and ring setting, steps the position on command, and flags the turnover notch. It also rotates the one-hot letter into the wiring's contact frame, then rotates the wiring's result back into the letter frame. It sits directly on both sides of the wiring filter: it drives the filter's forward and inverse inputs and consumes the filter's forward and inverse outputs, for both the forward and the reflected paths.

## Interface
- NOTCH, 4, letter index (0..25) at which AT_NOTCH asserts; 4 = 'E', turnover of Rotor II.
- CLK  in  1  rising-edge clock
- RESET_N  in  1  synchronous, active-low reset
- LOAD  in  1  load POS_IN/RING_IN this cycle
- POS_IN  in  5  start position 0..25
- RING_IN  in  5  ring setting 0..25
- STEP  in  1  advance position by one
- POS  out  5  current position
- AT_NOTCH  out  1  POS == NOTCH
- IN_VALID  in  1  FWD_IN/INV_IN valid this cycle
- FWD_IN, INV_IN  in  26  one-hot letter, forward and return path
- FWD_TO_WIRE, INV_TO_WIRE  out  26  rotated vectors to the wiring filter (combinational)
- FWD_FROM_WIRE, INV_FROM_WIRE  in  26  wiring filter outputs
- FWD_OUT, INV_OUT  out  26  registered letter-frame results
- OUT_VALID  out  1  FWD_OUT/INV_OUT valid
- ERR  out  1  sticky one-hot violation (see Configuration)

## Operation
- Offset: off = (POS − RING) mod 26. RING is the internal ring register.
- Entry rotate: TO_WIRE[(i+off) mod 26] = IN[i].
- Exit rotate: OUT[j] = FROM_WIRE[(j+off) mod 26].
- Both paths use the same off.
- Mod-26 arithmetic is done on 6-bit intermediates. No 5-bit wrap is allowed.
- LOAD: POS←POS_IN and RING←RING_IN. A field with a value of 26..31 is ignored and its register is unchanged.
- STEP without LOAD: POS←(POS==25) ? 0 : POS+1.
- LOAD and STEP in the same cycle: LOAD wins and STEP is dropped.
- AT_NOTCH decodes the registered POS. Stepping order and double-step sequencing belong to the upstream controller.
- IN_VALID: FWD_OUT/INV_OUT capture the exit-rotated FROM_WIRE values. OUT_VALID←1.
- No IN_VALID: OUT_VALID←0 and the data registers hold.
- Reset values: POS=0, RING=0, FWD_OUT=0, INV_OUT=0, OUT_VALID=0, ERR=0.

## Timing
- POS/RING update on the edge after LOAD/STEP.
- The TO_WIRE paths are combinational from IN and the registered off. The wiring filter is combinational, so the full round trip is a single combinational path.
- Latency from IN_VALID to OUT_VALID is 1 cycle. No backpressure.
- STEP and IN_VALID in the same cycle: the captured result uses the pre-step off. The post-step off applies from the next cycle.
- RESET_N low mid-operation: all registers take their reset values on that edge, and any pending result is lost.

## Configuration
- ROTOR_ONEHOT_CHECK_EN defined: in each IN_VALID cycle, ERR is set if FWD_IN or INV_IN is not exactly one-hot. ERR clears only on reset.
- Macro undefined: ERR is tied to 0 and there is no check logic.

## Structure
- Shared package enigma_pkg holds:
  - LETTERS = 26
  - letter_t (5-bit)
  - onehot_t (26-bit)
  - the notch constants for Rotors I–V
- Sub-module onehot_rotate: a 26-bit rotate by 0..25 with a direction input. It is instantiated four times: two entry, two exit.

## Test plan
- Reset with RESET_N=0 → POS=0, OUT_VALID=0, FWD_OUT=0, ERR=0.
- LOAD POS_IN=1, RING_IN=0; FWD_IN=bit0 → FWD_TO_WIRE=bit1. With FROM_WIRE looped to TO_WIRE, FWD_OUT=bit0 and OUT_VALID=1 one cycle after IN_VALID.
- LOAD POS_IN=0, RING_IN=1; INV_IN=bit0 → INV_TO_WIRE=bit25 (off=25).
- LOAD POS_IN=24, then 2×STEP → POS=25 then 0. LOAD POS_IN=3 plus STEP → POS=4, AT_NOTCH=1. LOAD POS_IN=30 → POS unchanged.
- LOAD and STEP together with POS_IN=7 → POS=7. STEP and IN_VALID together with POS=1, FWD_IN=bit0, loopback → TO_WIRE=bit1 in that cycle.
- With ROTOR_ONEHOT_CHECK_EN: IN_VALID with FWD_IN=0x3 → ERR=1 next cycle, held until reset. Without the macro, the same stimulus → ERR=0.
